// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter control sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package counter_ctrl_pkg;

  // Width of the counter's preset value (switch bank and num register).
  localparam int DATA_W = 3;

  // FSM state encoding; exported on the state output, so the values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LOAD  = 2'd3
  } state_t;

endpackage

// File: rtl/counter_ctrl_if.sv
// Board-side bundle of the counter control sequencer: raw buttons and switch inputs,
// plus the strobes/preset/status driven towards the counter.
// master = the sequencer (drives cnt/load/num/state/running); slave = board I/O and counter.
interface counter_ctrl_if;
  import counter_ctrl_pkg::*;

  logic              btn_run;   // raw run/pause button, active-high, asynchronous
  logic              btn_load;  // raw load button, active-high, asynchronous
  logic [DATA_W-1:0] sw_num;    // preset switches, sampled on a load event
  logic              cnt;       // count enable to the counter
  logic              load;      // one-cycle load strobe to the counter
  logic [DATA_W-1:0] num;       // registered preset value
  state_t            state;     // current FSM state
  logic              running;   // high while in RUN

  modport master (
    input  btn_run, btn_load, sw_num,
    output cnt, load, num, state, running
  );

  modport slave (
    output btn_run, btn_load, sw_num,
    input  cnt, load, num, state, running
  );

endinterface

// File: rtl/counter_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter and rising-edge press pulse.
// Latency: level follows a stable input on edge 2+DEBOUNCE_CYC; evt is high the cycle after.
// Backpressure: none; evt is a free-running one-cycle pulse.
// Ports: clk, clr_n (async active-low), btn (raw), level (debounced), evt (press pulse).
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic clr_n,
  input  logic btn,
  output logic level,
  output logic evt
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] run_cnt;
  logic          flip;

  // The mismatch has persisted for DEBOUNCE_CYC cycles once this edge is counted.
  assign flip = (sync2 != level) && (run_cnt == LAST);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      run_cnt <= '0;
      level   <= 1'b0;
      evt     <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      if (sync2 == level || flip) begin
        run_cnt <= '0;
      end else begin
        run_cnt <= run_cnt + CW'(1);
      end
      if (flip) begin
        level <= sync2;
      end
      // Only a flip towards 1 is a press; releases are silent.
      evt <= flip & sync2;
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// Control sequencer for the 3-bit loadable counter: debounced run/pause and load buttons,
// load sequencing with return-state memory, and a count-rate prescaler.
// Latency: state changes on the edge after a press pulse; load is the Moore output of LOAD.
// Backpressure: none; events arriving during LOAD are dropped.
// Ports: clk, clr_n (async active-low), bus (counter_ctrl_if.master: buttons, switches,
// cnt/load/num strobes and state/running status).
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4,
  parameter int TICK_DIV     = 2
) (
  input  logic             clk,
  input  logic             clr_n,
  counter_ctrl_if.master   bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PSC_LAST = PW'(TICK_DIV - 1);

  logic              run_evt;
  logic              load_evt;
  logic              run_level;
  logic              load_level;
  logic              unused_levels;

  state_t            state_q;
  state_t            state_d;
  state_t            ret_q;
  state_t            ret_d;
  logic              latch;
  logic [PW-1:0]     psc_q;
  logic              wrap;
  logic              cnt_q;
  logic [DATA_W-1:0] num_q;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_run_btn (
    .clk   (clk),
    .clr_n (clr_n),
    .btn   (bus.btn_run),
    .level (run_level),
    .evt   (run_evt)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_load_btn (
    .clk   (clk),
    .clr_n (clr_n),
    .btn   (bus.btn_load),
    .level (load_level),
    .evt   (load_evt)
  );

  // Debounced levels are not needed here; only the press pulses drive the FSM.
  assign unused_levels = run_level ^ load_level;

  // Next state. Load has priority over run; LOAD itself ignores both events.
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    latch   = 1'b0;
    case (state_q)
      ST_LOAD: begin
        state_d = ret_q;
      end
      default: begin
        if (load_evt) begin
          state_d = ST_LOAD;
          latch   = 1'b1;
          // Loading from IDLE parks the counter in PAUSE afterwards.
          ret_d   = (state_q == ST_RUN) ? ST_RUN : ST_PAUSE;
        end else if (run_evt) begin
          state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= ST_IDLE;
      ret_q   <= ST_IDLE;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
    end
  end

  assign wrap = (psc_q == PSC_LAST);

  // Prescaler restarts at 0 on every entry into RUN so the first count step
  // always lands TICK_DIV cycles after entry, including a resume from PAUSE.
  // cnt is gated with the next state so it is never high outside RUN.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      psc_q <= '0;
      cnt_q <= 1'b0;
      num_q <= '0;
    end else begin
      if (state_q == ST_LOAD || (state_d == ST_RUN && state_q != ST_RUN)) begin
        psc_q <= '0;
      end else if (state_q == ST_RUN) begin
        psc_q <= wrap ? '0 : psc_q + PW'(1);
      end
      cnt_q <= (state_q == ST_RUN) && (state_d == ST_RUN) && wrap;
      if (latch) begin
        num_q <= bus.sw_num;
      end
    end
  end

  assign bus.cnt     = cnt_q;
  assign bus.load    = (state_q == ST_LOAD);
  assign bus.num     = num_q;
  assign bus.state   = state_q;
  assign bus.running = (state_q == ST_RUN);

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: directed scenarios plus randomized button activity,
// compared each cycle against a reference model built from the behavioural rules.
// Clock 10 ns, DEBOUNCE_CYC=4, TICK_DIV=2.
module tb_counter_ctrl;
  import counter_ctrl_pkg::*;

  localparam int DC = 4;
  localparam int TD = 2;

  logic clk   = 1'b1;
  logic clr_n = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   pulses  = 0;
  int   loads   = 0;

  always #5 clk = ~clk;

  counter_ctrl_if bus();

  counter_ctrl #(.DEBOUNCE_CYC(DC), .TICK_DIV(TD)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  // ---------------- reference model ----------------
  // Button b: the debouncer sees the raw level from two edges earlier; the debounced
  // level flips once the last DC of those samples all disagree with it.
  logic [1:0]        raw_in;
  logic [1:0]        m_rawh [2];
  logic [DC-1:0]     m_synh [2];
  logic [1:0]        m_level;
  logic [1:0]        m_evt;
  state_t            m_state, m_ns, m_ret, m_ret_n;
  logic [DATA_W-1:0] m_num;
  int                m_age;   // edges spent in RUN since entry
  logic              m_cnt;

  assign raw_in = {bus.btn_load, bus.btn_run};

  always_comb begin
    m_ns    = m_state;
    m_ret_n = m_ret;
    if (m_state == ST_LOAD) begin
      m_ns = m_ret;
    end else if (m_evt[1]) begin
      m_ns    = ST_LOAD;
      m_ret_n = (m_state == ST_RUN) ? ST_RUN : ST_PAUSE;
    end else if (m_evt[0]) begin
      m_ns = (m_state == ST_RUN) ? ST_PAUSE : ST_RUN;
    end
  end

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int b = 0; b < 2; b++) begin
        m_rawh[b] <= '0;
        m_synh[b] <= '0;
      end
      m_level <= '0;
      m_evt   <= '0;
      m_state <= ST_IDLE;
      m_ret   <= ST_IDLE;
      m_num   <= '0;
      m_age   <= 0;
      m_cnt   <= 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        m_rawh[b] <= {m_rawh[b][0], raw_in[b]};
        m_synh[b] <= {m_synh[b][DC-2:0], m_rawh[b][1]};
        if ({m_synh[b][DC-2:0], m_rawh[b][1]} == {DC{~m_level[b]}}) begin
          m_level[b] <= ~m_level[b];
          m_evt[b]   <= ~m_level[b];
        end else begin
          m_evt[b] <= 1'b0;
        end
      end
      m_state <= m_ns;
      m_ret   <= m_ret_n;
      if (m_ns == ST_LOAD && m_state != ST_LOAD) m_num <= bus.sw_num;
      if (m_ns == ST_RUN) m_age <= (m_state == ST_RUN) ? m_age + 1 : 0;
      // A count step every TD edges of uninterrupted RUN.
      m_cnt <= (m_state == ST_RUN) && (m_ns == ST_RUN) && (((m_age + 1) % TD) == 0);
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One clock, then compare every output with the model on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (bus.cnt === 1'b1) pulses++;
    if (bus.load === 1'b1) loads++;
    check("cnt",     32'(bus.cnt),     32'(m_cnt));
    check("load",    32'(bus.load),    32'(m_state == ST_LOAD));
    check("num",     32'(bus.num),     32'(m_num));
    check("state",   32'(bus.state),   32'(m_state));
    check("running", 32'(bus.running), 32'(m_state == ST_RUN));
  endtask

  task automatic idle(input int n);
    bus.btn_run  = 1'b0;
    bus.btn_load = 1'b0;
    repeat (n) tick();
  endtask

  task automatic press(input logic r, input logic l, input int n);
    bus.btn_run  = r;
    bus.btn_load = l;
    repeat (n) tick();
    bus.btn_run  = 1'b0;
    bus.btn_load = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int found;
    bus.btn_run  = 1'b0;
    bus.btn_load = 1'b0;
    bus.sw_num   = '0;

    // Reset held 4 ns.
    #2 clr_n = 1'b0;
    #2;
    check("rst_cnt",   32'(bus.cnt),   0);
    check("rst_load",  32'(bus.load),  0);
    check("rst_num",   32'(bus.num),   0);
    check("rst_state", 32'(bus.state), 32'(ST_IDLE));
    check("rst_run",   32'(bus.running), 0);
    #2 clr_n = 1'b1;

    pulses = 0;
    idle(20);
    check("idle_no_cnt", pulses, 0);

    // First run press: RUN seven cycles after the press, cnt every 2nd cycle after.
    bus.btn_run = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 6)  check("run_lat_pre",  32'(bus.state), 32'(ST_IDLE));
      if (i == 7)  check("run_lat",      32'(bus.state), 32'(ST_RUN));
      if (i == 8)  check("run_cnt_e1",   32'(bus.cnt), 0);
      if (i == 9)  check("run_cnt_e2",   32'(bus.cnt), 1);
      if (i == 10) check("run_cnt_e3",   32'(bus.cnt), 0);
    end
    bus.btn_run = 1'b0;
    pulses = 0;
    idle(12);
    check("run_rate", pulses, 6);

    // Second press: PAUSE, no count steps.
    bus.btn_run = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 7) check("pause_lat", 32'(bus.state), 32'(ST_PAUSE));
    end
    bus.btn_run = 1'b0;
    pulses = 0;
    idle(12);
    check("pause_no_cnt", pulses, 0);

    // Bounce shorter than the debounce window.
    press(1'b1, 1'b0, 2);
    idle(1);
    press(1'b1, 1'b0, 2);
    idle(12);
    check("bounce_state", 32'(bus.state), 32'(ST_PAUSE));

    // Back to RUN, then load 6.
    press(1'b1, 1'b0, 10);
    idle(12);
    check("resume_run", 32'(bus.state), 32'(ST_RUN));
    bus.sw_num   = 3'b110;
    bus.btn_load = 1'b1;
    loads = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 7) begin
        check("ld_strobe", 32'(bus.load), 1);
        check("ld_num",    32'(bus.num),  6);
        check("ld_cnt",    32'(bus.cnt),  0);
      end
      if (i == 8) check("ld_ret_run", 32'(bus.state), 32'(ST_RUN));
      if (i == 9) check("ld_cnt_e1", 32'(bus.cnt), 0);
      if (i == 10) check("ld_cnt_e2", 32'(bus.cnt), 1);
    end
    bus.btn_load = 1'b0;
    idle(12);
    check("ld_once", loads, 1);

    // To PAUSE, then both buttons together: load only, return to PAUSE.
    press(1'b1, 1'b0, 10);
    idle(12);
    bus.sw_num = 3'b011;
    loads = 0;
    bus.btn_run  = 1'b1;
    bus.btn_load = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 7) check("both_load", 32'(bus.num), 3);
      if (i == 8) check("both_ret",  32'(bus.state), 32'(ST_PAUSE));
    end
    idle(20);
    check("both_once",  loads, 1);
    check("both_pause", 32'(bus.state), 32'(ST_PAUSE));

    // Randomized button activity.
    for (int k = 0; k < 60; k++) begin
      bus.sw_num = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: press(1'b1, 1'b0, $urandom_range(1, 12));
        1: press(1'b0, 1'b1, $urandom_range(1, 12));
        2: press(1'b1, 1'b1, $urandom_range(1, 12));
        default: press(($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
                       $urandom_range(1, 3));
      endcase
      idle($urandom_range(0, 14));
    end

    // Set up RUN with a non-zero preset, then reset asynchronously during a cnt pulse.
    idle(16);
    bus.sw_num = 3'b101;
    press(1'b0, 1'b1, 10);
    idle(12);
    if (m_state != ST_RUN) begin
      press(1'b1, 1'b0, 10);
      idle(12);
    end
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      tick();
      if (bus.cnt === 1'b1) found = 1;
    end
    check("cnt_before_rst", found, 1);
    #1;
    clr_n = 1'b0;
    bus.btn_run = 1'b1;
    #1;
    check("arst_cnt",   32'(bus.cnt),   0);
    check("arst_load",  32'(bus.load),  0);
    check("arst_num",   32'(bus.num),   0);
    check("arst_state", 32'(bus.state), 32'(ST_IDLE));
    #1 clr_n = 1'b1;

    // Button held through reset: exactly one press event after release.
    repeat (30) tick();
    bus.btn_run = 1'b0;
    idle(12);
    check("held_rst_run", 32'(bus.state), 32'(ST_RUN));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Control sequencer for the board's 3-bit loadable counter / LED / 7-segment datapath. Turns two raw push-buttons and a 3-bit switch bank into the counter's `cnt` (count enable) and `load` strobes and its `num` preset. Handles debounce, run/pause toggling, load sequencing and count-rate prescaling. Sits between board I/O and the counter; its `cnt`, `load` and `num` outputs wire directly to the counter's ports of the same names.

## Interface
- `DEBOUNCE_CYC`, 4: consecutive stable cycles required before a button level is accepted (≥1).
- `TICK_DIV`, 2: clock cycles per count step while running (≥1).
- `clk`  in  1  single system clock; all logic on the rising edge.
- `clr_n`  in  1  asynchronous, active-low reset.
- `btn_run`  in  1  raw run/pause button, active-high, asynchronous to `clk`.
- `btn_load`  in  1  raw load button, active-high, asynchronous to `clk`.
- `sw_num`  in  3  preset value from the switches; sampled only on a load event.
- `cnt`  out  1  count-enable to the counter; the counter steps on each edge where `cnt`=1.
- `load`  out  1  one-cycle load strobe to the counter.
- `num`  out  3  registered preset value for the counter.
- `state`  out  2  current FSM state, encoded as in the package.
- `running`  out  1  high in RUN.

## Operation
- Per button:
  - 2-flop synchroniser, then a debounce counter. The counter runs while the synchronised level differs from the debounced level and clears when they match.
  - The debounced level flips when the mismatch has lasted `DEBOUNCE_CYC` cycles.
  - Press event `evt` is a registered one-cycle pulse on the debounced level's rising edge. Releases generate no event.
- FSM states and transitions:
  - IDLE: reset state, `cnt`=0. `run_evt` → RUN.
  - RUN: `run_evt` → PAUSE.
  - PAUSE: `run_evt` → RUN.
  - Any of IDLE/RUN/PAUSE: `load_evt` → LOAD. On the same edge, `sw_num` is latched into `num`, and the return state is saved (RUN→RUN, PAUSE→PAUSE, IDLE→PAUSE).
  - LOAD: lasts exactly one cycle, then goes to the saved return state.
- Simultaneous `run_evt` and `load_evt`: load wins and `run_evt` is discarded. Any event arriving while in LOAD is discarded.
- Prescaler, width $clog2(`TICK_DIV`) (min 1):
  - RUN: counts 0..`TICK_DIV`-1, then wraps.
  - IDLE/PAUSE: holds.
  - LOAD: cleared to 0.
- `cnt`: registered. High for the one cycle following each prescaler wrap in RUN. With `TICK_DIV`=1, `cnt` stays high continuously in RUN. Always 0 outside RUN, so `cnt` and `load` are never high together.
- `num`: changes only at load latch; otherwise holds.

## Timing
- Reset (clr_n=0, immediate, asynchronous):
  - Outputs: `cnt`=0, `load`=0, `num`=0, `state`=IDLE, `running`=0.
  - Internal state: synchronisers, debounced levels and counters all 0; prescaler 0.
- Button latency: after an input rises and stays stable, the debounced level rises on rising edge 2+`DEBOUNCE_CYC`. `evt` is high for the following cycle. The state changes on the edge that samples `evt`.
- Glitches shorter than `DEBOUNCE_CYC` cycles (post-sync) produce no event.
- `load`: Moore output of LOAD. High exactly one cycle, starting the cycle after `load_evt`. `num` is valid in that same cycle.
- First `cnt` pulse after entering RUN (from IDLE, PAUSE or LOAD) comes `TICK_DIV` cycles after entry.
- Button held through reset: produces exactly one event after `clr_n` releases, because the debounced level resets to 0.
- Reset mid-LOAD or mid-debounce: the operation is abandoned; no deferred strobe.

## Structure
- Package `counter_ctrl_pkg`: state encoding IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, LOAD=2'd3; the counter data width constant (3).
- Sub-module `btn_debounce`:
  - Parameter `DEBOUNCE_CYC`; ports `clk`, `clr_n`, `btn`, `level`, `evt`.
  - Instantiated twice.
- Top level: FSM, prescaler, `num` register.

## Test plan
All scenarios use `DEBOUNCE_CYC`=4, `TICK_DIV`=2, 10 ns clock.
- Reset: hold `clr_n`=0 for 4 ns, release → all outputs 0, `state`=IDLE; no `cnt` pulses while buttons idle.
- `btn_run` high 10 cycles → one `evt`; `state`=RUN 7 cycles after press; `cnt` high every 2nd cycle thereafter. Second 10-cycle press → PAUSE, `cnt`=0, counter value frozen.
- Bounce: `btn_run` high 2 cycles, low 1, high 2, low → no event; `state` unchanged.
- In RUN with `sw_num`=3'b110, press `btn_load` → `load`=1 for exactly one cycle with `num`=6, `cnt`=0 during it; returns to RUN; first `cnt` pulse 2 cycles after `load`.
- Both buttons pressed on the same cycle from PAUSE → single `load` pulse; `state` returns to PAUSE, not RUN.
- In RUN, drop `clr_n` mid-cycle while `cnt`=1 → `cnt`, `load`, `num` go to 0 before the next edge; `state`=IDLE.
